motor_pwm_driver: RTL and testbench

- Downstream stage of the image processor. Consumes the one-cycle `command_valid` / `motor_command_in[2:0]` pulse and drives left and right motor PWM outputs.
- Each side's duty cycle ramps toward a per-command target, updating only at PWM period boundaries, so outputs never glitch.
- A command watchdog brings the vehicle to a controlled stop when the upstream frame pipeline stalls.

---
 rtl/motor_pwm_driver.sv | 179 +++++++++++++++++
 tb/tb_motor_pwm_driver.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/motor_pwm_driver.sv
// Dual-side motor PWM driver: decodes turn/straight/stop commands into
// per-side duty targets, ramps the applied duties toward those targets
// only at PWM period boundaries, and stops the vehicle if commands dry up.
module motor_pwm_driver #(
    parameter int PWM_PERIOD      = 1000,
    parameter int DUTY_STRAIGHT   = 600,
    parameter int DUTY_FAST       = 800,
    parameter int DUTY_SLOW       = 300,
    parameter int RAMP_STEP       = 20,
    parameter int WATCHDOG_CYCLES = 2000000,
    parameter int DW              = $clog2(PWM_PERIOD + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          enable,
    input  logic          command_valid,
    input  logic [2:0]    motor_command_in,
    output logic          pwm_left,
    output logic          pwm_right,
    output logic [DW-1:0] duty_left,
    output logic [DW-1:0] duty_right,
    output logic          motor_active,
    output logic          timeout_flag,
    output logic          illegal_cmd
);

    localparam int WW = $clog2(WATCHDOG_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] tgt_l_q, tgt_l_d, tgt_r_q, tgt_r_d;
    logic [DW-1:0] duty_l_q, duty_l_d, duty_r_q, duty_r_d;
    logic [WW-1:0] wdog_q, wdog_d;
    logic          timeout_q, timeout_d;
    logic          illegal_q, illegal_d;
    logic          pwm_l_q, pwm_l_d, pwm_r_q, pwm_r_d;

    logic          cmd_ok, cmd_legal, cmd_go, cmd_stop, boundary;
    logic [DW-1:0] cmd_tl, cmd_tr;

    // Move one step toward the target, landing exactly on it when close enough.
    function automatic logic [DW-1:0] ramp_toward(input logic [DW-1:0] cur,
                                                  input logic [DW-1:0] tgt);
        logic [DW-1:0] step;
        step = DW'(RAMP_STEP);
        if (tgt >= cur) begin
            ramp_toward = ((tgt - cur) <= step) ? tgt : cur + step;
        end else begin
            ramp_toward = ((cur - tgt) <= step) ? tgt : cur - step;
        end
    endfunction

    // Qualify the strobe and translate the command code into side targets.
    always_comb begin
        cmd_ok    = command_valid && enable;
        cmd_legal = 1'b1;
        cmd_tl    = '0;
        cmd_tr    = '0;
        case (motor_command_in)
            3'b001: begin cmd_tl = DW'(DUTY_SLOW);     cmd_tr = DW'(DUTY_FAST);     end
            3'b010: begin cmd_tl = DW'(DUTY_FAST);     cmd_tr = DW'(DUTY_SLOW);     end
            3'b100: begin cmd_tl = DW'(DUTY_STRAIGHT); cmd_tr = DW'(DUTY_STRAIGHT); end
            3'b000: begin cmd_tl = '0;                 cmd_tr = '0;                 end
            default: cmd_legal = 1'b0;
        endcase
        cmd_go   = cmd_ok && cmd_legal && (motor_command_in != 3'b000);
        cmd_stop = cmd_ok && (motor_command_in == 3'b000);
    end

    // Counter, boundary ramping, PWM compare and the IDLE/RUN/STOP controller.
    always_comb begin
        state_d   = state_q;
        tgt_l_d   = tgt_l_q;
        tgt_r_d   = tgt_r_q;
        wdog_d    = wdog_q;
        timeout_d = timeout_q;
        illegal_d = cmd_ok && !cmd_legal;

        boundary = (cnt_q == DW'(PWM_PERIOD - 1));
        cnt_d    = boundary ? '0 : cnt_q + DW'(1);
        duty_l_d = boundary ? ramp_toward(duty_l_q, tgt_l_q) : duty_l_q;
        duty_r_d = boundary ? ramp_toward(duty_r_q, tgt_r_q) : duty_r_q;
        pwm_l_d  = (cnt_q < duty_l_q);
        pwm_r_d  = (cnt_q < duty_r_q);

        case (state_q)
            IDLE: begin
                if (cmd_go) begin
                    state_d   = RUN;
                    tgt_l_d   = cmd_tl;
                    tgt_r_d   = cmd_tr;
                    wdog_d    = '0;
                    timeout_d = 1'b0;
                end
            end
            RUN: begin
                wdog_d = wdog_q + WW'(1);
                if (cmd_go) begin
                    tgt_l_d   = cmd_tl;
                    tgt_r_d   = cmd_tr;
                    wdog_d    = '0;
                    timeout_d = 1'b0;
                end else if (cmd_stop) begin
                    state_d = STOP;
                    tgt_l_d = '0;
                    tgt_r_d = '0;
                    wdog_d  = '0;
                end else if (!enable) begin
                    state_d = STOP;
                    tgt_l_d = '0;
                    tgt_r_d = '0;
                end else if (wdog_q == WW'(WATCHDOG_CYCLES - 1)) begin
                    state_d   = STOP;
                    tgt_l_d   = '0;
                    tgt_r_d   = '0;
                    timeout_d = 1'b1;
                end
            end
            STOP: begin
                tgt_l_d = '0;
                tgt_r_d = '0;
                if (cmd_go) begin
                    state_d   = RUN;
                    tgt_l_d   = cmd_tl;
                    tgt_r_d   = cmd_tr;
                    wdog_d    = '0;
                    timeout_d = 1'b0;
                end else if (boundary && (duty_l_d == '0) && (duty_r_d == '0)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // All state registers, cleared immediately by the asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            tgt_l_q   <= '0;
            tgt_r_q   <= '0;
            duty_l_q  <= '0;
            duty_r_q  <= '0;
            wdog_q    <= '0;
            timeout_q <= 1'b0;
            illegal_q <= 1'b0;
            pwm_l_q   <= 1'b0;
            pwm_r_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            tgt_l_q   <= tgt_l_d;
            tgt_r_q   <= tgt_r_d;
            duty_l_q  <= duty_l_d;
            duty_r_q  <= duty_r_d;
            wdog_q    <= wdog_d;
            timeout_q <= timeout_d;
            illegal_q <= illegal_d;
            pwm_l_q   <= pwm_l_d;
            pwm_r_q   <= pwm_r_d;
        end
    end

    assign pwm_left     = pwm_l_q;
    assign pwm_right    = pwm_r_q;
    assign duty_left    = duty_l_q;
    assign duty_right   = duty_r_q;
    assign motor_active = (state_q != IDLE);
    assign timeout_flag = timeout_q;
    assign illegal_cmd  = illegal_q;

endmodule

// File: tb/tb_motor_pwm_driver.sv
// Directed bench for motor_pwm_driver with a small period so ramps,
// stops, watchdog expiry and async reset all fit in a short run.
module tb_motor_pwm_driver;

    localparam int P  = 10;
    localparam int DW = $clog2(P + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b1;
    logic          command_valid = 1'b0;
    logic [2:0]    motor_command_in = 3'b000;
    logic          pwm_left, pwm_right, motor_active, timeout_flag, illegal_cmd;
    logic [DW-1:0] duty_left, duty_right;

    int n_checks = 0;
    int n_fail   = 0;
    int ref_cnt  = 0;
    int nl, nr;

    motor_pwm_driver #(
        .PWM_PERIOD(P), .DUTY_STRAIGHT(6), .DUTY_FAST(8), .DUTY_SLOW(2),
        .RAMP_STEP(2), .WATCHDOG_CYCLES(100)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .command_valid(command_valid), .motor_command_in(motor_command_in),
        .pwm_left(pwm_left), .pwm_right(pwm_right),
        .duty_left(duty_left), .duty_right(duty_right),
        .motor_active(motor_active), .timeout_flag(timeout_flag),
        .illegal_cmd(illegal_cmd)
    );

    always #5 clk = ~clk;

    // Reference PWM counter position, used to place strobes and find boundaries.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) ref_cnt <= 0;
        else        ref_cnt <= (ref_cnt == P - 1) ? 0 : ref_cnt + 1;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish, limit 100000");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_duties(input string tag, input int el, input int er);
        check({tag, "_duty_l"}, 32'(duty_left), 32'(el));
        check({tag, "_duty_r"}, 32'(duty_right), 32'(er));
    endtask

    // Advance to just after the next boundary edge.
    task automatic next_boundary();
        int k = 0;
        do begin
            @(posedge clk); #1;
            k++;
        end while (ref_cnt != 0 && k < 25);
        check("boundary_reached", 32'(ref_cnt == 0), 32'd1);
    endtask

    // One-cycle strobe placed at counter position 3, returns at the following negedge.
    task automatic send(input logic [2:0] c);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (ref_cnt != 3 && k < 25);
        command_valid    = 1'b1;
        motor_command_in = c;
        @(negedge clk);
        command_valid    = 1'b0;
        motor_command_in = 3'b000;
    endtask

    task automatic count_pwm(output int cl, output int cr);
        cl = 0;
        cr = 0;
        for (int i = 0; i < P; i++) begin
            @(negedge clk);
            cl += int'(pwm_left);
            cr += int'(pwm_right);
        end
    endtask

    initial begin
        // Reset state
        #1;
        check("rst_pwm_l", 32'(pwm_left), 0);
        check("rst_pwm_r", 32'(pwm_right), 0);
        check_duties("rst", 0, 0);
        check("rst_active", 32'(motor_active), 0);
        check("rst_timeout", 32'(timeout_flag), 0);
        check("rst_illegal", 32'(illegal_cmd), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // 1: straight ramps 0->2->4->6 and holds
        send(3'b100);
        check("t1_active", 32'(motor_active), 1);
        next_boundary(); check_duties("t1_b1", 2, 2);
        next_boundary(); check_duties("t1_b2", 4, 4);
        next_boundary(); check_duties("t1_b3", 6, 6);
        next_boundary(); check_duties("t1_hold", 6, 6);
        count_pwm(nl, nr);
        check("t1_pwm_l_high", 32'(nl), 6);
        check("t1_pwm_r_high", 32'(nr), 6);

        // 2: left turn
        send(3'b001);
        next_boundary(); check_duties("t2_b1", 4, 8);
        next_boundary(); check_duties("t2_b2", 2, 8);
        next_boundary(); check_duties("t2_hold", 2, 8);

        // 3: stop ramps down and returns to IDLE
        send(3'b000);
        next_boundary(); check_duties("t3_b1", 0, 6);
        next_boundary(); check_duties("t3_b2", 0, 4);
        check("t3_active_stop", 32'(motor_active), 1);
        next_boundary(); check_duties("t3_b3", 0, 2);
        next_boundary(); check_duties("t3_b4", 0, 0);
        check("t3_active_idle", 32'(motor_active), 0);
        count_pwm(nl, nr);
        check("t3_pwm_l_low", 32'(nl), 0);
        check("t3_pwm_r_low", 32'(nr), 0);

        // 4: watchdog expiry
        send(3'b100);
        next_boundary(); check_duties("t4_b1", 2, 2);
        next_boundary(); check_duties("t4_b2", 4, 4);
        next_boundary(); check_duties("t4_b3", 6, 6);
        check("t4_no_timeout_yet", 32'(timeout_flag), 0);
        for (int i = 0; i < 150 && !timeout_flag; i++) @(negedge clk);
        check("t4_timeout_set", 32'(timeout_flag), 1);
        next_boundary(); check_duties("t4_down1", 4, 4);
        next_boundary(); check_duties("t4_down2", 2, 2);
        next_boundary(); check_duties("t4_down3", 0, 0);
        check("t4_active_idle", 32'(motor_active), 0);
        check("t4_timeout_sticky", 32'(timeout_flag), 1);
        send(3'b100);
        check("t4_timeout_cleared", 32'(timeout_flag), 0);
        next_boundary(); check_duties("t4_re_b1", 2, 2);
        next_boundary(); check_duties("t4_re_b2", 4, 4);
        next_boundary(); check_duties("t4_re_b3", 6, 6);

        // 5: illegal code, enable-low ramp down, strobes ignored while disabled
        send(3'b011);
        check("t5_illegal_pulse", 32'(illegal_cmd), 1);
        @(negedge clk);
        check("t5_illegal_one_cycle", 32'(illegal_cmd), 0);
        next_boundary(); check_duties("t5_unchanged", 6, 6);
        check("t5_active", 32'(motor_active), 1);
        @(negedge clk); enable = 1'b0;
        next_boundary(); check_duties("t5_dis_b1", 4, 4);
        next_boundary(); check_duties("t5_dis_b2", 2, 2);
        next_boundary(); check_duties("t5_dis_b3", 0, 0);
        check("t5_dis_idle", 32'(motor_active), 0);
        send(3'b100);
        check("t5_dis_cmd_ignored", 32'(motor_active), 0);
        next_boundary(); check_duties("t5_dis_cmd_duty", 0, 0);
        send(3'b111);
        check("t5_dis_no_illegal", 32'(illegal_cmd), 0);
        enable = 1'b1;

        // 6: async reset mid-period at duty 6
        send(3'b100);
        next_boundary(); next_boundary(); next_boundary();
        check_duties("t6_pre", 6, 6);
        do @(negedge clk); while (ref_cnt != 5);
        check("t6_pwm_l_before", 32'(pwm_left), 1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_pwm_l", 32'(pwm_left), 0);
        check("t6_pwm_r", 32'(pwm_right), 0);
        check_duties("t6_rst", 0, 0);
        check("t6_active", 32'(motor_active), 0);
        check("t6_timeout", 32'(timeout_flag), 0);
        @(negedge clk);
        rst_n = 1'b1;
        next_boundary(); check_duties("t6_after", 0, 0);
        check("t6_idle_after", 32'(motor_active), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
